// File: rtl/led_pwm_pkg.sv
// Shared register map constants and CTRL layout for the led_pwm block.
package led_pwm_pkg;

  localparam int unsigned ADDR_CTRL      = 0;
  localparam int unsigned ADDR_PRESCALE  = 1;
  localparam int unsigned ADDR_DUTY_BASE = 2;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_INV_BIT = 1;

  typedef struct packed {
    logic inv;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM channel: effective-duty latch, optional fade stepping and phase compare.
// Macro LED_PWM_FADE_EN selects fading duty updates instead of direct loads.
module led_pwm_chan (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inv,
  input  logic       wrap,
  input  logic [7:0] n,
  input  logic [7:0] duty,
  output logic       led
);

  logic [7:0] duty_eff;

  // Tracking DUTY while disabled makes the enable edge start with the programmed duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_eff <= 8'd0;
    end else if (!en) begin
      duty_eff <= duty;
    end else if (wrap) begin
`ifdef LED_PWM_FADE_EN
      if (duty_eff < duty) begin
        duty_eff <= duty_eff + 8'd1;
      end else if (duty_eff > duty) begin
        duty_eff <= duty_eff - 8'd1;
      end
`else
      duty_eff <= duty;
`endif
    end
  end

  assign led = en ? ((n < duty_eff) ^ inv) : inv;

endmodule

// File: rtl/led_pwm.sv
// Multi-channel LED PWM with a small register interface and shared prescaler.
// Macro LED_PWM_FADE_EN (optional) enables per-channel duty fading at period wrap.
module led_pwm
  import led_pwm_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic [NCH-1:0]    led
);

  ctrl_t      ctrl;
  logic [7:0] prescale;
  logic [7:0] duty [NCH];
  logic [7:0] pre_cnt;
  logic [7:0] n;
  logic       tick;
  logic       wrap;
  logic [7:0] rd_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= 8'd0;
      for (int i = 0; i < NCH; i++) begin
        duty[i] <= 8'd0;
      end
    end else if (wr_en) begin
      if (addr == ADDR_W'(ADDR_CTRL)) begin
        ctrl.en  <= wr_data[CTRL_EN_BIT];
        ctrl.inv <= wr_data[CTRL_INV_BIT];
      end
      if (addr == ADDR_W'(ADDR_PRESCALE)) begin
        prescale <= wr_data;
      end
      for (int i = 0; i < NCH; i++) begin
        if (addr == ADDR_W'(ADDR_DUTY_BASE + i)) begin
          duty[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_mux = 8'd0;
    if (addr == ADDR_W'(ADDR_CTRL)) begin
      rd_mux = {6'd0, ctrl};
    end
    if (addr == ADDR_W'(ADDR_PRESCALE)) begin
      rd_mux = prescale;
    end
    for (int i = 0; i < NCH; i++) begin
      if (addr == ADDR_W'(ADDR_DUTY_BASE + i)) begin
        rd_mux = duty[i];
      end
    end
  end

  // Read data is captured from pre-write register state, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

  assign tick = ctrl.en && (pre_cnt >= prescale);
  assign wrap = tick && (n == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst || !ctrl.en) begin
      pre_cnt <= 8'd0;
      n       <= 8'd0;
    end else if (tick) begin
      pre_cnt <= 8'd0;
      n       <= n + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    led_pwm_chan u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (ctrl.en),
      .inv  (ctrl.inv),
      .wrap (wrap),
      .n    (n),
      .duty (duty[i]),
      .led  (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm: read scoreboard plus per-scenario PWM checks.
module tb_led_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [2:0] led;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_exp_t;

  rd_exp_t rd_q[$];

  led_pwm #(.NCH(3), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .addr     (addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .led      (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read results are popped from the scoreboard when the DUT raises rd_valid.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_valid) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL spurious_rd_valid: got rd_valid=1 data=%0d, required no read pending", rd_data);
      end else begin
        e = rd_q.pop_front();
        if (rd_data !== e.data || cyc !== e.due) begin
          miscompares++;
          $display("[TB] FAIL read_data: got %0d at cycle %0d, required %0d at cycle %0d",
                   rd_data, cyc, e.data, e.due);
        end
      end
    end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      vectors++;
      miscompares++;
      e = rd_q.pop_front();
      $display("[TB] FAIL missing_rd_valid: got rd_valid=0 at cycle %0d, required data %0d", cyc, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, input logic [7:0] exp);
    rd_exp_t e;
    e.data = exp;
    e.due  = cyc + 1;
    rd_q.push_back(e);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic count_high(input int ch, input int len, output int highs);
    highs = 0;
    for (int i = 0; i < len; i++) begin
      if (led[ch]) highs++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (led !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_led: got %b, required 000", led);
    end
    vectors++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_rd: got valid=%b data=%0d, required 0/0", rd_valid, rd_data);
    end
    read_reg(4'd0, 8'd0);
    read_reg(4'd1, 8'd0);
    tick();
  endtask

  task automatic test_basic_pwm();
    int h;
    write_reg(4'd1, 8'd0);
    write_reg(4'd2, 8'd64);
    write_reg(4'd0, 8'd1);
    for (int p = 0; p < 2; p++) begin
      count_high(0, 64, h);
      vectors++;
      if (h !== 64) begin
        miscompares++;
        $display("[TB] FAIL basic_high p%0d: got %0d high cycles, required 64", p, h);
      end
      count_high(0, 192, h);
      vectors++;
      if (h !== 0) begin
        miscompares++;
        $display("[TB] FAIL basic_low p%0d: got %0d high cycles, required 0", p, h);
      end
    end
    write_reg(4'd0, 8'd0);
  endtask

  task automatic test_prescale();
    int h;
    write_reg(4'd1, 8'd3);
    write_reg(4'd3, 8'd128);
    write_reg(4'd0, 8'd1);
    count_high(1, 512, h);
    vectors++;
    if (h !== 512) begin
      miscompares++;
      $display("[TB] FAIL presc_128_high: got %0d, required 512", h);
    end
    count_high(1, 512, h);
    vectors++;
    if (h !== 0) begin
      miscompares++;
      $display("[TB] FAIL presc_128_low: got %0d, required 0", h);
    end
    vectors++;
    if (led[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL presc_period: got led1=%b at cycle 1024, required 1", led[1]);
    end
    write_reg(4'd0, 8'd0);
    write_reg(4'd3, 8'd0);
    write_reg(4'd0, 8'd1);
    count_high(1, 1024, h);
    vectors++;
    if (h !== 0) begin
      miscompares++;
      $display("[TB] FAIL presc_duty0: got %0d, required 0", h);
    end
    write_reg(4'd0, 8'd0);
    write_reg(4'd3, 8'd255);
    write_reg(4'd0, 8'd1);
    count_high(1, 1024, h);
    vectors++;
    if (h !== 1020) begin
      miscompares++;
      $display("[TB] FAIL presc_duty255: got %0d, required 1020", h);
    end
    write_reg(4'd0, 8'd0);
    write_reg(4'd1, 8'd0);
  endtask

`ifndef LED_PWM_FADE_EN
  task automatic test_midperiod();
    int h;
    write_reg(4'd2, 8'd50);
    write_reg(4'd0, 8'd1);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      if (led[0]) h++;
      if (i == 100) begin
        addr    = 4'd2;
        wr_data = 8'd200;
        wr_en   = 1'b1;
      end
      tick();
      wr_en = 1'b0;
    end
    vectors++;
    if (h !== 50) begin
      miscompares++;
      $display("[TB] FAIL midperiod_current: got %0d, required 50", h);
    end
    count_high(0, 256, h);
    vectors++;
    if (h !== 200) begin
      miscompares++;
      $display("[TB] FAIL midperiod_next: got %0d, required 200", h);
    end
    write_reg(4'd0, 8'd0);
  endtask
`else
  task automatic test_fade();
    int h;
    int exp_q[$];
    write_reg(4'd2, 8'd10);
    write_reg(4'd0, 8'd1);
    exp_q.push_back(10);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      if (led[0]) h++;
      if (i == 100) begin
        addr    = 4'd2;
        wr_data = 8'd13;
        wr_en   = 1'b1;
      end
      tick();
      wr_en = 1'b0;
    end
    vectors++;
    if (h !== exp_q.pop_front()) begin
      miscompares++;
      $display("[TB] FAIL fade_p0: got %0d, required 10", h);
    end
    exp_q.push_back(11);
    exp_q.push_back(12);
    exp_q.push_back(13);
    exp_q.push_back(13);
    for (int p = 1; p <= 4; p++) begin
      int e;
      e = exp_q.pop_front();
      count_high(0, 256, h);
      vectors++;
      if (h !== e) begin
        miscompares++;
        $display("[TB] FAIL fade_p%0d: got %0d, required %0d", p, h, e);
      end
    end
    write_reg(4'd0, 8'd0);
  endtask
`endif

  task automatic test_invert();
    int h;
    write_reg(4'd4, 8'd0);
    write_reg(4'd0, 8'd3);
    vectors++;
    if (led[2] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL inv_immediate: got %b, required 1", led[2]);
    end
    count_high(2, 256, h);
    vectors++;
    if (h !== 256) begin
      miscompares++;
      $display("[TB] FAIL inv_duty0: got %0d, required 256", h);
    end
    write_reg(4'd0, 8'd2);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (led !== 3'b111) begin
        miscompares++;
        $display("[TB] FAIL inv_disabled: got %b, required 111", led);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    rd_exp_t e;
    write_reg(4'd1, 8'd5);
    e.data = 8'd5;
    e.due  = cyc + 1;
    rd_q.push_back(e);
    addr    = 4'd1;
    wr_data = 8'd9;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    read_reg(4'd1, 8'd9);
    write_reg(4'd7, 8'hAA);
    read_reg(4'd7, 8'd0);
    read_reg(4'd15, 8'd0);
    read_reg(4'd0, 8'd2);
    write_reg(4'd3, 8'd77);
    read_reg(4'd3, 8'd77);
    read_reg(4'd4, 8'd0);
    tick();
    tick();
  endtask

  task automatic test_reset_midrun();
    int h;
    write_reg(4'd1, 8'd0);
    write_reg(4'd2, 8'd128);
    write_reg(4'd0, 8'd1);
    count_high(0, 30, h);
    rst     = 1'b1;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    addr    = 4'd0;
    wr_data = 8'hFF;
    tick();
    rst   = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    vectors++;
    if (led !== 3'b000 || rd_valid !== 1'b0 || rd_data !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: got led=%b valid=%b data=%0d, required 000/0/0",
               led, rd_valid, rd_data);
    end
    count_high(0, 10, h);
    vectors++;
    if (h !== 0) begin
      miscompares++;
      $display("[TB] FAIL midrun_led: got %0d high cycles, required 0", h);
    end
    for (int a = 0; a < 5; a++) begin
      read_reg(4'(a), 8'd0);
    end
    tick();
    tick();
  endtask

  initial begin
    $display("[TB] starting led_pwm bench");
    test_reset();
    test_basic_pwm();
    test_prescale();
`ifndef LED_PWM_FADE_EN
    test_midperiod();
`else
    test_fade();
`endif
    test_invert();
    test_back_to_back();
    test_reset_midrun();
    vectors++;
    if (rd_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL reads_pending: got %0d outstanding, required 0", rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have parameter NCH, default 3, number of PWM channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 4, register address width (2**ADDR_W >= NCH+2).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rd_en, input, 1, read strobe.
REQ-006 SHALL have port addr, input, ADDR_W, register address for reads and writes.
REQ-007 SHALL have port rd_data, output, 8, registered read data.
REQ-008 SHALL have port rd_valid, output, 1, read data valid pulse.
REQ-009 SHALL have port wr_en, input, 1, write strobe.
REQ-010 SHALL have port wr_data, input, 8, write data.
REQ-011 SHALL have port led, output, NCH, PWM outputs, one bit per channel.

Function
REQ-012 SHALL decode the register map as follows: addr 0 CTRL (bit0 EN, bit1 INV, bits7:2 read 0); addr 1 PRESCALE; addr 2+i DUTY[i] for i < NCH; all other addresses unmapped.
REQ-013 SHALL, on rd_en, return the addressed register on rd_data with rd_valid high exactly one cycle later; rd_valid SHALL be low in every other cycle.
REQ-014 SHALL return 0 for reads of unmapped addresses and SHALL ignore writes to them.
REQ-015 SHALL, when rd_en and wr_en hit the same address in the same cycle, return the pre-write value; the write SHALL land that cycle.
REQ-016 SHALL run an 8-bit prescaler: it counts up each clk; at pre_cnt >= PRESCALE it emits a one-cycle tick and clears to 0; period = (PRESCALE+1)*256 clk.
REQ-017 SHALL advance the 8-bit phase counter n by 1 per tick, wrapping 255->0.
REQ-018 SHALL drive led[i] = (n < duty_eff[i]) XOR INV; duty 0 = never active, 255 = active 255/256 of the period.
REQ-019 SHALL latch duty_eff[i] only on the tick where n wraps 255->0; DUTY writes mid-period SHALL NOT glitch the current period.
REQ-020 SHALL, while EN=0, hold pre_cnt and n at 0 and drive every led bit to INV; setting EN SHALL start at n=0 and load duty_eff from DUTY immediately.
REQ-021 SHALL make INV changes visible on led in the next cycle, regardless of EN.

Reset
REQ-022 SHALL clear CTRL, PRESCALE, all DUTY, duty_eff, pre_cnt and n to 0 on rst.
REQ-023 SHALL drive led = 0, rd_data = 0 and rd_valid = 0 in the cycle after rst; rst SHALL override any concurrent rd_en or wr_en.
REQ-024 SHALL abort an in-flight read on rst mid-operation: no rd_valid SHALL follow.

Configuration
REQ-025 SHALL, with macro LED_PWM_FADE_EN defined, step each duty_eff[i] by +-1 toward DUTY[i] at each 255->0 wrap instead of loading it directly, with no further change once equal; the enable load of REQ-020 also loads directly.
REQ-026 SHALL, without LED_PWM_FADE_EN, load duty_eff directly per REQ-019, with no fade logic synthesised.

Structure
REQ-027 SHALL place the register address constants (CTRL, PRESCALE, DUTY base) and CTRL bit indices in shared package led_pwm_pkg.
REQ-028 SHALL implement per-channel duty_eff latch, fade step and compare in sub-module led_pwm_chan, instantiated NCH times by generate.

Verification
REQ-029 The bench SHALL write PRESCALE=0, DUTY0=64, CTRL=1, and check led[0] is high for 64 and low for 192 cycles per 256-cycle period.
REQ-030 The bench SHALL set PRESCALE=3 and DUTY1=128, and check a 1024-cycle period with 512 high cycles; DUTY1=0 gives constant 0 and DUTY1=255 gives 1020 high cycles.
REQ-031 The bench SHALL write DUTY0=200 at n=100 while DUTY0=50, and check the current period stays at 50 and the next period is 200 (fade off).
REQ-032 The bench SHALL write CTRL=3 (INV), and check that DUTY2=0 gives constant 1; it SHALL then write CTRL=2 and check all led bits are 1 while disabled.
REQ-033 The bench SHALL write addr 1 and read addr 1 in the same cycle, and check the old value is returned with rd_valid one cycle later; reading an unmapped addr SHALL return 0.
REQ-034 The bench SHALL, with LED_PWM_FADE_EN, move DUTY0 from 10 to 13 while running, and check duty_eff reaches 11, 12 and 13 at three consecutive wraps; asserting rst mid-period SHALL give led = 0 and all registers 0.
